ahb_arbiter: RTL
================

# ahb_arbiter

Two-master AHB bus arbiter that produces the address-phase grants (`H_grant_m1`, `H_grant_m2`) and data-phase grants (`H_grant_data_m1`, `H_grant_data_m2`) consumed by `ahb_mux_M2S`. It resolves bus requests round-robin, never breaks a burst, and bounds bus tenure with a hold counter. The data-phase grant follows the address-phase grant whenever the slave signals `H_ready`, so master write data stays aligned with the pipelined AHB address/data phases.

## Interface
- `MAX_HOLD`, 8: accepted transfers an owner may complete while the other master waits before it must yield at a burst boundary; legal range 1..255.

- `H_clk`  input  1  bus clock; all state changes on the rising edge.
- `H_resetn`  input  1  asynchronous active-low reset.
- `H_busreq_m1`  input  1  master 1 bus request.
- `H_busreq_m2`  input  1  master 2 bus request.
- `H_trans_m1`  input  2  master 1 HTRANS (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- `H_trans_m2`  input  2  master 2 HTRANS.
- `H_ready`  input  1  slave-side HREADY; 1 means the current transfer completes this cycle.
- `H_grant_m1`  output  1  address-phase grant, master 1.
- `H_grant_m2`  output  1  address-phase grant, master 2.
- `H_grant_data_m1`  output  1  data-phase grant, master 1.
- `H_grant_data_m2`  output  1  data-phase grant, master 2.

## Operation
- All outputs are registered.
- `{H_grant_m1,H_grant_m2}` is 10, 01 or 00. It is never 11. A value of 00 makes the downstream mux drive IDLE.
- State machine: IDLE (grants 00), OWN_M1 (10), OWN_M2 (01).
- Round-robin pointer `last`: records the most recent owner. Reset value is M2, so M1 wins the first tie.
- Owner transfer type `cur_trans` is `H_trans_m1` in OWN_M1, `H_trans_m2` in OWN_M2, and 00 in IDLE.
- Arbitration is evaluated only on edges where `H_ready`=1. With `H_ready`=0, the state, pointer, counter and both grant pairs hold.
- Burst lock: in OWN_Mx with `cur_trans` equal to SEQ (11) or BUSY (01), the state holds regardless of requests.
- Transitions from IDLE:
  - Both requesting: grant the master other than `last`.
  - One requesting: grant that master.
  - None requesting: stay in IDLE.
- Transitions from OWN_Mx when not burst-locked (y denotes the other master):
  - `req_y`=1 and (`req_x`=0 or `hold_cnt`>=`MAX_HOLD`): go to OWN_My.
  - `req_y`=0 and `req_x`=0: go to IDLE.
  - Otherwise: stay.
- Every entry into OWN_Mx sets `last` to x.
- `hold_cnt`, width 8:
  - Cleared on reset, on every state change, and in IDLE.
  - Incremented on each `H_ready`=1 edge where the owner's `cur_trans[1]`=1 (NONSEQ/SEQ).
  - Saturates at `MAX_HOLD`.
- Data grant: on each `H_ready`=1 edge, `H_grant_data_m1` <= `H_grant_m1` and `H_grant_data_m2` <= `H_grant_m2`, both taking the pre-edge values.
- Simultaneous events:
  - A request drop and the other master's request on the same edge: handover proceeds.
  - Counter saturation during SEQ: no switch until the burst ends.
- Reset mid-burst: all outputs go to 0 immediately and asynchronously. The masters must restart the transfer.

## Timing
- Reset values: `H_grant_m1`=0, `H_grant_m2`=0, `H_grant_data_m1`=0, `H_grant_data_m2`=0; state IDLE, `last`=M2, `hold_cnt`=0.
- Request to grant: 1 cycle. A request sampled at edge n with `H_ready`=1 gives the grant valid after edge n.
- Address grant to data grant: 1 `H_ready`=1 cycle. Each wait state (`H_ready`=0) adds 1 cycle.
- During a handover cycle, the old owner holds the data grant while the new owner holds the address grant. This is the standard pipelined overlap.
- No combinational path from inputs to outputs.

## Test plan
- Reset with both requests high, then release reset. Expected: first edge gives grant 10; the next edge gives `H_grant_data_m1`=1 and `H_grant_data_m2`=0.
- M1 owns the bus and issues NONSEQ then 3×SEQ while `req_m2`=1, with `MAX_HOLD`=1. Expected: grant stays 10 through all SEQ beats and switches to 01 on the edge after M1 presents IDLE or NONSEQ. Data grant switches one cycle later.
- Both masters request continuously, every transfer is a single NONSEQ, `MAX_HOLD`=2. Expected: ownership alternates M1, M2, M1, … with 2 accepted transfers each.
- Hold `H_ready`=0 for 3 cycles while M1 drops its request and M2 requests. Expected: both grant pairs frozen for 3 cycles; the switch to 01 occurs on the first `H_ready`=1 edge.
- Both requests drop. Expected: grant becomes 00 next edge and the data grant becomes 00 one `H_ready` edge later. A subsequent lone `req_m2` then gives grant 01 after 1 cycle.
- Assert `H_resetn`=0 mid-burst while grant is 01. Expected: all four grant outputs are 0 before the next clock edge; after release, M1 wins the first tie.

Source files
------------

// File: rtl/ahb_arbiter.sv
`timescale 1ns/1ps
// Two-master AHB arbiter: round-robin address-phase grants with burst lock and hold limit.
// Latency: request sampled on an H_ready edge -> address grant after that edge; data grant one H_ready edge later.
// Backpressure: H_ready=0 freezes state, pointer, hold counter and both grant pairs.
//
// Ports:
//   H_clk, H_resetn            bus clock, asynchronous active-low reset
//   H_busreq_m1/_m2            master bus requests
//   H_trans_m1/_m2             master HTRANS (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
//   H_ready                    slave HREADY, transfer completes when 1
//   H_grant_m1/_m2             address-phase grants (never both high)
//   H_grant_data_m1/_m2        data-phase grants, address grants delayed by one H_ready edge
module ahb_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       H_clk,
    input  logic       H_resetn,
    input  logic       H_busreq_m1,
    input  logic       H_busreq_m2,
    input  logic [1:0] H_trans_m1,
    input  logic [1:0] H_trans_m2,
    input  logic       H_ready,
    output logic       H_grant_m1,
    output logic       H_grant_m2,
    output logic       H_grant_data_m1,
    output logic       H_grant_data_m2
);

    // Encoding chosen so each address grant is a state flop bit with no decode.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        OWN_M1 = 2'b01,
        OWN_M2 = 2'b10
    } state_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    state_t     state;
    state_t     state_nxt;
    logic       last_m2;          // 1: M2 was the most recent owner, 0: M1
    logic       last_m2_nxt;
    logic [7:0] hold_cnt;
    logic [7:0] hold_cnt_nxt;
    logic [1:0] cur_trans;
    logic       req_own;
    logic       req_oth;
    logic       burst_lock;
    logic       hold_expired;

    always_ff @(posedge H_clk or negedge H_resetn) begin
        if (!H_resetn) begin
            state    <= IDLE;
            last_m2  <= 1'b1;
            hold_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            last_m2  <= last_m2_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        last_m2_nxt  = last_m2;
        hold_cnt_nxt = hold_cnt;
        cur_trans    = 2'b00;
        req_own      = 1'b0;
        req_oth      = 1'b0;

        case (state)
            OWN_M1: begin
                cur_trans = H_trans_m1;
                req_own   = H_busreq_m1;
                req_oth   = H_busreq_m2;
            end
            OWN_M2: begin
                cur_trans = H_trans_m2;
                req_own   = H_busreq_m2;
                req_oth   = H_busreq_m1;
            end
            default: ;
        endcase

        // BUSY (01) and SEQ (11) are exactly the codes with bit 0 set: mid-burst.
        burst_lock   = (state != IDLE) && cur_trans[0];
        hold_expired = (hold_cnt >= HOLD_MAX);

        if (H_ready) begin
            case (state)
                IDLE: begin
                    // On a tie M1 wins only if M2 owned last.
                    if (H_busreq_m1 && (!H_busreq_m2 || last_m2))
                        state_nxt = OWN_M1;
                    else if (H_busreq_m2)
                        state_nxt = OWN_M2;
                end
                OWN_M1: begin
                    if (!burst_lock) begin
                        if (req_oth && (!req_own || hold_expired))
                            state_nxt = OWN_M2;
                        else if (!req_oth && !req_own)
                            state_nxt = IDLE;
                    end
                end
                OWN_M2: begin
                    if (!burst_lock) begin
                        if (req_oth && (!req_own || hold_expired))
                            state_nxt = OWN_M1;
                        else if (!req_oth && !req_own)
                            state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase

            // Counter measures tenure of the current owner only.
            if ((state_nxt != state) || (state_nxt == IDLE))
                hold_cnt_nxt = 8'd0;
            else if (cur_trans[1] && !hold_expired)
                hold_cnt_nxt = hold_cnt + 8'd1;

            if ((state_nxt == OWN_M1) && (state != OWN_M1))
                last_m2_nxt = 1'b0;
            else if ((state_nxt == OWN_M2) && (state != OWN_M2))
                last_m2_nxt = 1'b1;
        end
    end

    assign H_grant_m1 = state[0];
    assign H_grant_m2 = state[1];

    // Data phase trails the address phase by one completed transfer.
    always_ff @(posedge H_clk or negedge H_resetn) begin
        if (!H_resetn) begin
            H_grant_data_m1 <= 1'b0;
            H_grant_data_m2 <= 1'b0;
        end else if (H_ready) begin
            H_grant_data_m1 <= H_grant_m1;
            H_grant_data_m2 <= H_grant_m2;
        end
    end

endmodule
